wb_arbiter_n: RTL and testbench
===============================

Name: wb_arbiter_n

Overview:
Parametrised N-master Wishbone B4 classic arbiter. It is the successor to the fixed 2-master arbiter and sits between the CPU's IF/MEM ports, plus any future DMA or debug masters, and the address-decoding mux. It supports selectable fixed-priority or round-robin arbitration and holds bus ownership for the whole cyc. It exports the current grant for debug/LEDs.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
ARB_ROUND_ROBIN, 0, 1 = round-robin, 0 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
wbm_adr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master k at slice k
wbm_dat_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data
wbm_sel_i  in  NUM_MASTERS*SELECT_WIDTH  per-master byte select
wbm_we_i  in  NUM_MASTERS  per-master write enable
wbm_stb_i  in  NUM_MASTERS  per-master strobe
wbm_cyc_i  in  NUM_MASTERS  per-master cycle request
wbm_dat_o  out  DATA_WIDTH  slave read data, broadcast to all masters
wbm_ack_o  out  NUM_MASTERS  per-master ack
wbm_err_o  out  NUM_MASTERS  per-master err
wbm_rty_o  out  NUM_MASTERS  per-master rty
wbs_adr_o  out  ADDR_WIDTH  to slave
wbs_dat_o  out  DATA_WIDTH  to slave
wbs_sel_o  out  SELECT_WIDTH  to slave
wbs_we_o, wbs_stb_o, wbs_cyc_o  out  1 each  to slave
wbs_dat_i  in  DATA_WIDTH  from slave
wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  from slave
grant_o  out  NUM_MASTERS  registered one-hot grant, 0 when idle
busy_o  out  1  OR of grant_o

Behaviour:
- Reset is asynchronous and active-low on rst_ni. While rst_ni=0: grant_o=0, busy_o=0, last-grant pointer = NUM_MASTERS-1. All wbs_* outputs are 0. All wbm_ack/err/rty_o are 0.
- States:
  - IDLE: grant_o=0.
  - OWNED: exactly one bit of grant_o is set.
- IDLE -> OWNED: at the clock edge where any wbm_cyc_i bit is 1.
  - Fixed priority: grant the lowest set index.
  - Round-robin: grant the first set index scanning upward from (last+1) mod NUM_MASTERS; update last to the granted index.
- Arbitration latency is 1 cycle: a request sampled at edge t drives the slave from cycle t+1.
- OWNED -> IDLE: at the edge where the granted master's cyc is 0.
  - One idle cycle always separates consecutive ownerships, even when another request is pending.
  - Other masters' requests never pre-empt the owner while its cyc stays high (bus lock across multiple stb).
- Datapath (combinational from grant_o):
  - wbs_adr/dat/sel/we/stb/cyc_o = granted master's inputs, gated to 0 when idle.
  - wbs_cyc_o additionally ANDs the live wbm_cyc_i of the granted master, so a master abort drops the slave cyc in the same cycle.
- Return path:
  - wbm_ack/err/rty_o[k] = wbs_ack/err/rty_i AND grant_o[k].
  - Non-granted masters always see 0.
  - wbm_dat_o = wbs_dat_i, unmasked.
- Requests arriving while OWNED stay pending; there is no queueing beyond the live cyc level.
- NUM_MASTERS=1: grant is fixed to master 0 whenever its cyc is high; the same 1-cycle latency applies.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Enabled:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each cycle in OWNED with wbs_stb_o=1 and no slave ack/err/rty.
  - It clears on any slave response, on entering IDLE, and on reset.
  - When the count equals TIMEOUT_CYCLES: wbm_err_o of the owner pulses 1 for one cycle and wbs_cyc_o/wbs_stb_o are forced 0.
  - Forcing continues until the owner drops cyc, then normal release.
- Disabled: no counter exists and a stalled slave hangs the bus indefinitely.

Test Plan:
- Reset: rst_ni=0 mid-transfer with master 1 owning -> grant_o=0 and wbs_cyc_o=0 in the same cycle, no wbm_ack_o pulses; after release, master 0 wins first in both modes.
- Fixed priority, NUM_MASTERS=4: cyc on masters 1 and 3 at the same edge -> grant_o=4'b0010 next cycle; master 3 is granted 2 cycles after master 1 drops cyc.
- Round-robin, NUM_MASTERS=3, all three cyc held high, each doing one ack'd access then dropping cyc -> grant order 0, 1, 2, 0 with one idle cycle between each.
- Bus lock: master 0 does 3 back-to-back stb/ack transfers with cyc high while master 1 requests -> master 1 is not granted until master 0's cyc falls; wbm_ack_o[1] stays 0 throughout.
- Abort: owner drops cyc while a slave ack is pending -> wbs_cyc_o=0 in the same cycle, grant_o=0 next edge, and a late ack is not forwarded.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never acks -> owner sees wbm_err_o=1 exactly 8 stalled cycles after stb, and wbs_stb_o is forced to 0.

Source files
------------

// File: rtl/wb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_n
// Description : N-master Wishbone B4 classic arbiter. Grants one master per
//               bus cycle, using fixed-priority or round-robin arbitration,
//               and holds the grant for the whole cyc. It forwards the
//               owner's request to the single slave port and routes the
//               slave response back to the owner only.
//               Optional watchdog: define WB_ARB_TIMEOUT_EN to abort an
//               owner whose slave stalls for TIMEOUT_CYCLES cycles.
// Ports       : clk_i/rst_ni           clock, async active-low reset
//               wbm_*_i / wbm_*_o      packed per-master ports, master k at slice k
//               wbs_*_o / wbs_*_i      single slave port
//               grant_o / busy_o       registered one-hot grant and its OR
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_n #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
    parameter int ARB_ROUND_ROBIN = 0,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]              wbm_we_i,
    input  logic [NUM_MASTERS-1:0]              wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]              wbm_cyc_i,
    output logic [DATA_WIDTH-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]              wbm_ack_o,
    output logic [NUM_MASTERS-1:0]              wbm_err_o,
    output logic [NUM_MASTERS-1:0]              wbm_rty_o,
    output logic [ADDR_WIDTH-1:0]               wbs_adr_o,
    output logic [DATA_WIDTH-1:0]               wbs_dat_o,
    output logic [SELECT_WIDTH-1:0]             wbs_sel_o,
    output logic                                wbs_we_o,
    output logic                                wbs_stb_o,
    output logic                                wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]               wbs_dat_i,
    input  logic                                wbs_ack_i,
    input  logic                                wbs_err_i,
    input  logic                                wbs_rty_i,
    output logic [NUM_MASTERS-1:0]              grant_o,
    output logic                                busy_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;

    logic                   any_req;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_MASTERS-1:0] pick;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   to_fire;   // one-cycle watchdog error pulse
    logic                   to_force;  // suppress slave cyc/stb after a timeout

    // ------------------------------------------------------------------
    // Arbitration: choose the winner among the live cyc requests
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        idx      = 0;
        pick_idx = '0;
        pick     = '0;
        any_req  = |wbm_cyc_i;
        if (ARB_ROUND_ROBIN != 0) begin
            // Scan offsets from the far end down so the smallest offset
            // after the last winner is the one that sticks.
            for (int i = NUM_MASTERS; i >= 1; i--) begin
                idx = int'(last_q) + i;
                if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
                if (wbm_cyc_i[idx]) pick_idx = IDX_W'(idx);
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (wbm_cyc_i[i]) pick_idx = IDX_W'(i);
            end
        end
        if (any_req) pick[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_OWNED;
                    grant_d = pick;
                    last_d  = pick_idx;
                end
            end
            default: begin
                // Only the owner's own cyc ends the tenure; a release always
                // passes through one IDLE cycle before the next grant.
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Request path: AND-OR mux keyed by the one-hot grant (zero when idle)
    // ------------------------------------------------------------------
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                wbs_adr_o = wbs_adr_o | wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                wbs_dat_o = wbs_dat_o | wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                wbs_sel_o = wbs_sel_o | wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
            end
        end
    end

    // Live cyc of the owner lets an abort drop the slave cycle immediately.
    assign owner_cyc = |(grant_q & wbm_cyc_i);
    assign owner_stb = |(grant_q & wbm_stb_i);
    assign wbs_we_o  = |(grant_q & wbm_we_i);
    assign wbs_cyc_o = owner_cyc & ~to_force;
    assign wbs_stb_o = owner_stb & ~to_force;

    // ------------------------------------------------------------------
    // Response path: only the owner sees ack/err/rty
    // ------------------------------------------------------------------
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = {NUM_MASTERS{wbs_ack_i}} & grant_q;
    assign wbm_err_o = {NUM_MASTERS{wbs_err_i | to_fire}} & grant_q;
    assign wbm_rty_o = {NUM_MASTERS{wbs_rty_i}} & grant_q;

    assign grant_o = grant_q;
    assign busy_o  = |grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: counts stalled strobe cycles of the current owner
    // ------------------------------------------------------------------
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit_q, to_hit_d;
    logic            to_limit;
    logic            slave_resp;

    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign to_limit   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) && (state_q == ST_OWNED);
    // to_hit_q remembers the abort so the error pulses once and the forcing
    // survives a late slave response, until the owner lets go of cyc.
    assign to_fire    = to_limit & ~to_hit_q;
    assign to_force   = to_limit | to_hit_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        to_hit_d = to_hit_q | to_fire;
        if (state_d == ST_IDLE) begin
            to_cnt_d = '0;
            to_hit_d = 1'b0;
        end else if (slave_resp) begin
            to_cnt_d = '0;
        end else if ((state_q == ST_OWNED) && wbs_stb_o) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            to_hit_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_hit_q <= to_hit_d;
        end
    end
`else
    // Without the watchdog a stalled slave holds the bus indefinitely.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign to_fire        = 1'b0;
    assign to_force       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_n
// Description : Self-checking bench for wb_arbiter_n. A 4-master fixed-priority
//               instance is driven from a vector table through a scoreboard;
//               a 3-master round-robin instance covers grant rotation, the
//               watchdog (when WB_ARB_TIMEOUT_EN is defined) and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- fixed-priority instance, 4 masters ----------------
    logic [127:0] fp_adr, fp_dat;
    logic [15:0]  fp_sel;
    logic [3:0]   fp_we, fp_stb, fp_cyc;
    logic [31:0]  fp_dat_o;
    logic [3:0]   fp_ack_o, fp_err_o, fp_rty_o;
    logic [31:0]  fp_s_adr, fp_s_dat, fp_s_dat_i;
    logic [3:0]   fp_s_sel;
    logic         fp_s_we, fp_s_stb, fp_s_cyc;
    logic         fp_s_ack, fp_s_err, fp_s_rty;
    logic [3:0]   fp_grant;
    logic         fp_busy;

    wb_arbiter_n #(.NUM_MASTERS(4), .ARB_ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) u_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .wbm_adr_i(fp_adr), .wbm_dat_i(fp_dat), .wbm_sel_i(fp_sel),
        .wbm_we_i(fp_we), .wbm_stb_i(fp_stb), .wbm_cyc_i(fp_cyc),
        .wbm_dat_o(fp_dat_o), .wbm_ack_o(fp_ack_o), .wbm_err_o(fp_err_o), .wbm_rty_o(fp_rty_o),
        .wbs_adr_o(fp_s_adr), .wbs_dat_o(fp_s_dat), .wbs_sel_o(fp_s_sel),
        .wbs_we_o(fp_s_we), .wbs_stb_o(fp_s_stb), .wbs_cyc_o(fp_s_cyc),
        .wbs_dat_i(fp_s_dat_i), .wbs_ack_i(fp_s_ack), .wbs_err_i(fp_s_err), .wbs_rty_i(fp_s_rty),
        .grant_o(fp_grant), .busy_o(fp_busy)
    );

    // ---------------- round-robin instance, 3 masters ----------------
    logic [95:0]  rr_adr, rr_dat;
    logic [11:0]  rr_sel;
    logic [2:0]   rr_we, rr_stb, rr_cyc;
    logic [31:0]  rr_dat_o;
    logic [2:0]   rr_ack_o, rr_err_o, rr_rty_o;
    logic [31:0]  rr_s_adr, rr_s_dat, rr_s_dat_i;
    logic [3:0]   rr_s_sel;
    logic         rr_s_we, rr_s_stb, rr_s_cyc;
    logic         rr_s_ack, rr_s_err, rr_s_rty;
    logic [2:0]   rr_grant;
    logic         rr_busy;

    wb_arbiter_n #(.NUM_MASTERS(3), .ARB_ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .wbm_adr_i(rr_adr), .wbm_dat_i(rr_dat), .wbm_sel_i(rr_sel),
        .wbm_we_i(rr_we), .wbm_stb_i(rr_stb), .wbm_cyc_i(rr_cyc),
        .wbm_dat_o(rr_dat_o), .wbm_ack_o(rr_ack_o), .wbm_err_o(rr_err_o), .wbm_rty_o(rr_rty_o),
        .wbs_adr_o(rr_s_adr), .wbs_dat_o(rr_s_dat), .wbs_sel_o(rr_s_sel),
        .wbs_we_o(rr_s_we), .wbs_stb_o(rr_s_stb), .wbs_cyc_o(rr_s_cyc),
        .wbs_dat_i(rr_s_dat_i), .wbs_ack_i(rr_s_ack), .wbs_err_i(rr_s_err), .wbs_rty_i(rr_s_rty),
        .grant_o(rr_grant), .busy_o(rr_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One row: inputs applied for one cycle and the outputs expected then.
    typedef struct {
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic        ack;
        logic        err;
        logic [3:0]  g;
        logic        wcyc;
        logic        wstb;
        logic [3:0]  acko;
        logic [3:0]  erro;
        logic [31:0] adr;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] dat;
    } exp_t;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA000_0001;
    localparam logic [31:0] A3 = 32'hA000_0003;

    vec_t tbl[19];
    exp_t sb_q[$];
    logic [31:0] rrg_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t        e;
        logic [31:0] d;
        int          order[4];
        order = '{0, 1, 2, 0};

        //            cyc      stb      ack   err   grant    wcyc  wstb  acko     erro     adr
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
        tbl[1]  = '{4'b1010, 4'b1010, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
        tbl[2]  = '{4'b1010, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, A1};
        tbl[3]  = '{4'b1010, 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, A1};
        tbl[4]  = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, A1};
        tbl[5]  = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
        tbl[6]  = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0000, A3};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000, A3};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
        tbl[9]  = '{4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
        tbl[10] = '{4'b0011, 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, A0};
        tbl[11] = '{4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, A0};
        tbl[12] = '{4'b0011, 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, A0};
        tbl[13] = '{4'b0011, 4'b0010, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, A0};
        tbl[14] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, A0};
        tbl[15] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
        tbl[16] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, A1};
        tbl[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, A1};
        tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};

        for (int k = 0; k < 4; k++) begin
            fp_adr[k*32 +: 32] = A0 + 32'(k);
            fp_dat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
        end
        for (int k = 0; k < 3; k++) begin
            rr_adr[k*32 +: 32] = 32'hB000_0000 + 32'(k);
            rr_dat[k*32 +: 32] = 32'hE000_0000 + 32'(k);
        end
        fp_sel = 16'hFFFF; fp_we = 4'b1000; fp_stb = '0; fp_cyc = '0;
        rr_sel = 12'hFFF;  rr_we = 3'b000;  rr_stb = '0; rr_cyc = '0;
        fp_s_dat_i = '0; fp_s_ack = 0; fp_s_err = 0; fp_s_rty = 0;
        rr_s_dat_i = '0; rr_s_ack = 0; rr_s_err = 0; rr_s_rty = 0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fp_grant", 32'(fp_grant), 32'h0);
        chk("rst_fp_busy", 32'(fp_busy), 32'h0);
        chk("rst_fp_wbs_cyc", 32'(fp_s_cyc), 32'h0);
        chk("rst_rr_grant", 32'(rr_grant), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- round-robin rotation 0,1,2,0 ----------------
        @(negedge clk);
        rr_cyc = 3'b111; rr_stb = 3'b111;
        rrg_q.push_back(32'(1) << order[0]);
        #1 chk("rr_idle_start", 32'(rr_grant), 32'h0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            rr_s_ack = 1'b1;
            #1;
            chk("rr_grant", 32'(rr_grant), rrg_q.pop_front());
            chk("rr_ack_o", 32'(rr_ack_o), 32'(1) << order[n]);
            chk("rr_adr_o", rr_s_adr, 32'hB000_0000 + 32'(order[n]));
            @(negedge clk);
            rr_s_ack = 1'b0;
            rr_cyc[order[n]] = 1'b0; rr_stb[order[n]] = 1'b0;
            #1 chk("rr_drop_cyc", 32'(rr_s_cyc), 32'h0);
            @(negedge clk);
            rr_cyc = 3'b111; rr_stb = 3'b111;
            if (n < 3) rrg_q.push_back(32'(1) << order[n+1]);
            #1 chk("rr_idle_gap", 32'(rr_grant), 32'h0);
        end
        @(negedge clk);
        rr_cyc = '0; rr_stb = '0;
        @(negedge clk);

        // ---------------- fixed-priority table through the scoreboard ----------------
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            d = $urandom;
            fp_cyc = tbl[i].cyc; fp_stb = tbl[i].stb;
            fp_s_ack = tbl[i].ack; fp_s_err = tbl[i].err; fp_s_dat_i = d;
            sb_q.push_back('{tbl[i], d});
            #1;
            e = sb_q.pop_front();
            chk($sformatf("fp_grant[%0d]", i), 32'(fp_grant), 32'(e.v.g));
            chk($sformatf("fp_busy[%0d]", i), 32'(fp_busy), 32'(|e.v.g));
            chk($sformatf("fp_wbs_cyc[%0d]", i), 32'(fp_s_cyc), 32'(e.v.wcyc));
            chk($sformatf("fp_wbs_stb[%0d]", i), 32'(fp_s_stb), 32'(e.v.wstb));
            chk($sformatf("fp_ack_o[%0d]", i), 32'(fp_ack_o), 32'(e.v.acko));
            chk($sformatf("fp_err_o[%0d]", i), 32'(fp_err_o), 32'(e.v.erro));
            chk($sformatf("fp_adr_o[%0d]", i), fp_s_adr, e.v.adr);
            chk($sformatf("fp_dat_o[%0d]", i), fp_dat_o, e.dat);
        end
        fp_s_ack = 0; fp_s_err = 0;

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- watchdog: slave never responds ----------------
        @(negedge clk);
        rr_cyc = 3'b100; rr_stb = 3'b100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_grant[%0d]", c), 32'(rr_grant), 32'h4);
            chk($sformatf("to_err_o[%0d]", c), 32'(rr_err_o), (c == 8) ? 32'h4 : 32'h0);
            chk($sformatf("to_stb_o[%0d]", c), 32'(rr_s_stb), (c < 8) ? 32'h1 : 32'h0);
            chk($sformatf("to_cyc_o[%0d]", c), 32'(rr_s_cyc), (c < 8) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        rr_cyc = '0; rr_stb = '0;
        @(negedge clk);
        #1 chk("to_release", 32'(rr_grant), 32'h0);
`endif

        // ---------------- reset mid-transfer with master 1 owning ----------------
        @(negedge clk);
        fp_cyc = 4'b0010; fp_stb = 4'b0010;
        rr_cyc = 3'b010;  rr_stb = 3'b010;
        @(negedge clk);
        #1;
        chk("mid_fp_grant", 32'(fp_grant), 32'h2);
        chk("mid_rr_grant", 32'(rr_grant), 32'h2);
        @(negedge clk);
        fp_s_ack = 1'b1; rr_s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_fp_grant", 32'(fp_grant), 32'h0);
        chk("rst_mid_fp_cyc", 32'(fp_s_cyc), 32'h0);
        chk("rst_mid_fp_ack", 32'(fp_ack_o), 32'h0);
        chk("rst_mid_rr_grant", 32'(rr_grant), 32'h0);
        chk("rst_mid_rr_cyc", 32'(rr_s_cyc), 32'h0);
        chk("rst_mid_rr_ack", 32'(rr_ack_o), 32'h0);
        @(negedge clk);
        fp_s_ack = 1'b0; rr_s_ack = 1'b0;
        fp_cyc = 4'b0011; fp_stb = 4'b0011;
        rr_cyc = 3'b011;  rr_stb = 3'b011;
        rst_n = 1'b1;
        #1 chk("post_rst_idle", 32'(fp_grant), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_fp_m0", 32'(fp_grant), 32'h1);
        chk("post_rst_rr_m0", 32'(rr_grant), 32'h1);
        @(negedge clk);
        fp_cyc = '0; fp_stb = '0; rr_cyc = '0; rr_stb = '0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
